// File: rtl/mem_addr_seq_pkg.sv
// Shared types and helpers for the DRAM address sequencer: FSM state encoding
// and the LBD -> row/col address split.
package mem_addr_seq_pkg;

  localparam int AA_W_DEF = 10;
  localparam int AA_W_MAX = 32;
  localparam int LBD_MAX  = 2 * AA_W_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_RAS,
    S_COL,
    S_PRE,
    S_REFR
  } state_e;

  // row = {lbd[2*aa_w-2], lbd[aa_w-2:0]}
  function automatic logic [AA_W_MAX-1:0] row_of(input logic [LBD_MAX-1:0] lbd,
                                                 input int aa_w);
    logic [LBD_MAX-1:0] lo, hi;
    lo = lbd & ((LBD_MAX'(1) << (aa_w - 1)) - LBD_MAX'(1));
    hi = ((lbd >> (2 * aa_w - 2)) & LBD_MAX'(1)) << (aa_w - 1);
    return AA_W_MAX'(lo | hi);
  endfunction

  // col = {lbd[2*aa_w-1], lbd[2*aa_w-3:aa_w-1]}
  function automatic logic [AA_W_MAX-1:0] col_of(input logic [LBD_MAX-1:0] lbd,
                                                 input int aa_w);
    logic [LBD_MAX-1:0] lo, hi;
    lo = (lbd >> (aa_w - 1)) & ((LBD_MAX'(1) << (aa_w - 1)) - LBD_MAX'(1));
    hi = ((lbd >> (2 * aa_w - 1)) & LBD_MAX'(1)) << (aa_w - 1);
    return AA_W_MAX'(lo | hi);
  endfunction

endpackage

// File: rtl/mem_addr_seq_refresh_timer.sv
// Refresh bookkeeping: free-running interval timer, single sticky pending flag
// and the RAS-only refresh row counter (wraps mod 2^AA_W).
module mem_refresh_timer
  import mem_addr_seq_pkg::*;
#(
  parameter int AA_W         = AA_W_DEF,
  parameter int REF_INTERVAL = 312
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            take_i,
  input  logic            done_i,
  output logic            pend_o,
  output logic [AA_W-1:0] row_o
);

  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [TW-1:0]   tmr_q, tmr_d;
  logic            pend_q, pend_d;
  logic [AA_W-1:0] row_q, row_d;
  logic            expire;

  // A second expiry while already pending collapses into the existing one.
  always_comb begin
    expire = (tmr_q == TW'(REF_INTERVAL - 1));
    tmr_d  = expire ? '0 : tmr_q + TW'(1);
    pend_d = expire | (pend_q & ~take_i);
    row_d  = done_i ? row_q + AA_W'(1) : row_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
      row_q  <= '0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      row_q  <= row_d;
    end
  end

  assign pend_o = pend_q;
  assign row_o  = row_q;

endmodule

// File: rtl/mem_addr_seq.sv
// DRAM address sequencer: owns the RAS/CAS cycle for one granted bus address.
// Define MEM_ADDR_SEQ_REFRESH_EN to compile in interleaved RAS-only refresh.
module mem_addr_seq
  import mem_addr_seq_pkg::*;
#(
  parameter int AA_W         = AA_W_DEF,
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int REF_INTERVAL = 312
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic [2*AA_W-1:0] LBD,
  input  logic              REQ,
  output logic              ACK,
  output logic              DONE,
  output logic              BUSY,
  output logic [AA_W-1:0]   AA,
  output logic              RAS_n,
  output logic              CAS_n,
  output logic              REF_ACTIVE
);

  localparam int MAXPH = (T_RCD + T_CAS > T_RP) ? T_RCD + T_CAS : T_RP;
  localparam int CNT_W = (MAXPH > 1) ? $clog2(MAXPH) : 1;

  if (T_RCD < 1 || T_CAS < 1 || T_RP < 1 || REF_INTERVAL < T_RCD + T_CAS + T_RP + 2)
  begin : g_bad_cfg
    $error("mem_addr_seq: illegal timing parameters");
  end

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AA_W-1:0] col_q, aa_q, row_w, col_w, ref_row;
  logic            ack_q, done_q, busy_q, ras_n_q, cas_n_q, ref_act_q, ref_pend;

  assign row_w = AA_W'(row_of(LBD_MAX'(LBD), AA_W));
  assign col_w = AA_W'(col_of(LBD_MAX'(LBD), AA_W));

`ifdef MEM_ADDR_SEQ_REFRESH_EN
  logic ref_take, ref_done;
  assign ref_take = (state_q == S_IDLE) && ref_pend;
  assign ref_done = (state_q == S_REFR) && (cnt_q == '0);

  mem_refresh_timer #(
    .AA_W         (AA_W),
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref (
    .clk_i  (sysclk),
    .rst_ni (sys_rst_n),
    .take_i (ref_take),
    .done_i (ref_done),
    .pend_o (ref_pend),
    .row_o  (ref_row)
  );
`else
  assign ref_pend = 1'b0;
  assign ref_row  = '0;
`endif

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      aa_q      <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ras_n_q   <= 1'b1;
      cas_n_q   <= 1'b1;
      ref_act_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Refresh wins over a waiting bus request.
          if (ref_pend) begin
            aa_q      <= ref_row;
            ras_n_q   <= 1'b0;
            ref_act_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(T_RCD + T_CAS - 1);
            state_q   <= S_REFR;
          end else if (REQ) begin
            aa_q    <= row_w;
            col_q   <= col_w;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ROW;
          end
        end
        S_ROW: begin
          ras_n_q <= 1'b0;
          cnt_q   <= CNT_W'(T_RCD - 1);
          state_q <= S_RAS;
        end
        S_RAS: begin
          if (cnt_q == '0) begin
            aa_q    <= col_q;
            cas_n_q <= 1'b0;
            cnt_q   <= CNT_W'(T_CAS - 1);
            state_q <= S_COL;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_COL: begin
          if (cnt_q == '0) begin
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= CNT_W'(T_RP - 1);
            state_q <= S_PRE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PRE: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_REFR: begin
          if (cnt_q == '0) begin
            ras_n_q   <= 1'b1;
            ref_act_q <= 1'b0;
            cnt_q     <= CNT_W'(T_RP - 1);
            state_q   <= S_PRE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ACK        = ack_q;
  assign DONE       = done_q;
  assign BUSY       = busy_q;
  assign AA         = aa_q;
  assign RAS_n      = ras_n_q;
  assign CAS_n      = cas_n_q;
  assign REF_ACTIVE = ref_act_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Directed bench for mem_addr_seq: bus-cycle timing tables, back-to-back REQ,
// async reset mid-cycle; refresh priority and row wrap when refresh is built in.
module tb_mem_addr_seq;

  logic        sysclk, sys_rst_n, REQ;
  logic [19:0] LBD;
  logic        ACK, DONE, BUSY, RAS_n, CAS_n, REF_ACTIVE;
  logic [9:0]  AA;
  int          nvec = 0;
  int          nerr = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  mem_addr_seq dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .LBD(LBD), .REQ(REQ),
    .ACK(ACK), .DONE(DONE), .BUSY(BUSY), .AA(AA),
    .RAS_n(RAS_n), .CAS_n(CAS_n), .REF_ACTIVE(REF_ACTIVE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl0();
    return {REF_ACTIVE, ACK, DONE, BUSY, RAS_n, CAS_n};
  endfunction

  // One bus cycle sampled on 8 falling edges after acceptance.
  // ctl = {REF_ACTIVE, ACK, DONE, BUSY, RAS_n, CAS_n}
  task automatic exp_cycle(input logic [9:0] row, input logic [9:0] col,
                           input logic [19:0] next_lbd, input bit hold);
    logic [5:0] ctl [8];
    ctl = '{6'b010111, 6'b000101, 6'b000101, 6'b000100,
            6'b000100, 6'b001111, 6'b000111, 6'b000011};
    for (int m = 0; m < 8; m++) begin
      @(negedge sysclk);
      chk($sformatf("ctl%0d", m), 32'(ctl0()), 32'(ctl[m]));
      chk($sformatf("aa%0d", m), 32'(AA), (m < 3) ? 32'(row) : 32'(col));
      if (m == 0) begin
        REQ = hold;
        LBD = next_lbd;
      end
    end
  endtask

`ifdef MEM_ADDR_SEQ_REFRESH_EN
  logic       rst1, REQ1, ACK1, DONE1, BUSY1, RAS1_n, CAS1_n, REF1;
  logic [7:0] LBD1;
  logic [3:0] AA1;

  mem_addr_seq #(.AA_W(4), .REF_INTERVAL(20)) dut1 (
    .sysclk(sysclk), .sys_rst_n(rst1), .LBD(LBD1), .REQ(REQ1),
    .ACK(ACK1), .DONE(DONE1), .BUSY(BUSY1), .AA(AA1),
    .RAS_n(RAS1_n), .CAS_n(CAS1_n), .REF_ACTIVE(REF1)
  );

  function automatic logic [5:0] ctl1();
    return {REF1, ACK1, DONE1, BUSY1, RAS1_n, CAS1_n};
  endfunction
`endif

  initial begin
    sys_rst_n = 1'b0;
    REQ       = 1'b1;
    LBD       = 20'hABCDE;
`ifdef MEM_ADDR_SEQ_REFRESH_EN
    rst1 = 1'b0;
    REQ1 = 1'b0;
    LBD1 = 8'hA5;
`endif
    repeat (2) @(negedge sysclk);
    chk("rst_ctl", 32'(ctl0()), 32'(6'b000011));
    chk("rst_aa", 32'(AA), 32'(0));
    sys_rst_n = 1'b1;

    // REQ held through reset: accepted on the first edge, then pulsed off.
    exp_cycle(10'h0DE, 10'h35E, 20'h80200, 1'b0);
    REQ = 1'b1;
    // Back-to-back with REQ held; LBD changes mid-cycle must not leak in.
    exp_cycle(10'h000, 10'h201, 20'h7FFFF, 1'b1);
    exp_cycle(10'h3FF, 10'h1FF, 20'hABCDE, 1'b1);
    exp_cycle(10'h0DE, 10'h35E, 20'hABCDE, 1'b0);

    // Async reset while in the CAS phase.
    REQ = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge sysclk);
      if (m == 0) REQ = 1'b0;
    end
    chk("col_phase", 32'(ctl0()), 32'(6'b000100));
    #1 sys_rst_n = 1'b0;
    #1 chk("arst_ctl", 32'(ctl0()), 32'(6'b000011));
    chk("arst_aa", 32'(AA), 32'(0));
    @(negedge sysclk);
    chk("arst_nodone", 32'(ctl0()), 32'(6'b000011));
    sys_rst_n = 1'b1;
    REQ = 1'b1;
    LBD = 20'h7FFFF;
    exp_cycle(10'h3FF, 10'h1FF, 20'h00000, 1'b0);

`ifdef MEM_ADDR_SEQ_REFRESH_EN
    // Pending is set on the 20th edge after release; REQ arrives with it.
    @(negedge sysclk);
    rst1 = 1'b1;
    repeat (20) @(posedge sysclk);
    #1 REQ1 = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge sysclk);
      chk($sformatf("refr%0d", m), 32'(ctl1()), 32'(6'b100101));
      chk($sformatf("refaa%0d", m), 32'(AA1), 32'(0));
    end
    @(negedge sysclk);
    chk("ref_pre0", 32'(ctl1()), 32'(6'b000111));
    @(negedge sysclk);
    chk("ref_pre1", 32'(ctl1()), 32'(6'b000111));
    @(negedge sysclk);
    chk("ref_idle", 32'(ctl1()), 32'(6'b000011));
    @(negedge sysclk);
    chk("r_ack", 32'(ctl1()), 32'(6'b010111));
    chk("r_row", 32'(AA1), 32'(4'h5));
    REQ1 = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("r_col", 32'(ctl1()), 32'(6'b000100));
    chk("r_colaa", 32'(AA1), 32'(4'hC));
    for (int r = 1; r <= 16; r++) begin
      for (int t = 0; t < 40 && REF1 !== 1'b1; t++) @(negedge sysclk);
      chk($sformatf("ref_seen%0d", r), 32'(REF1), 32'(1));
      chk($sformatf("ref_row%0d", r), 32'(AA1), 32'(r % 16));
      for (int t = 0; t < 10 && REF1 !== 1'b0; t++) @(negedge sysclk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
